// File: rtl/veggie_pkg.sv
// Shared types and screen constants for the veggie game loop.
package veggie_pkg;

  localparam int unsigned SCREEN_W      = 1024;
  localparam int unsigned SCREEN_H      = 768;
  localparam int unsigned SPAWN_X_BASE  = 256;
  localparam int unsigned BOTTOM_MARGIN = 12;
  localparam int unsigned TIMER_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FLY,
    ST_SLICED,
    ST_WAIT,
    ST_OVER
  } veggie_state_t;

endpackage

// File: rtl/veggie_round_controller_frame_timer.sv
// Loadable down-counter of frame strobes; saturates at zero and flags when empty.
module frame_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         done
);

  // Load takes priority; otherwise each tick counts down until zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
      done  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      done  <= (load_val == '0);
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
      done  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/veggie_round_controller.sv
// Per-veggie life cycle: spawn, flight, slice/miss detection, score and lives.
module veggie_round_controller #(
  parameter int unsigned SCREEN_H       = veggie_pkg::SCREEN_H,
  parameter int unsigned VEG_H          = 64,
  parameter int unsigned MIN_AIR_FRAMES = 16,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned MAX_LIVES      = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_done_in,
  input  logic        start_in,
  input  logic [15:0] random_in,
  input  logic        hit_in,
  input  logic [9:0]  veggie_y_in,
  output logic        load_out,
  output logic [10:0] spawn_x_out,
  output logic [9:0]  spawn_y_out,
  output logic [2:0]  x_vel_out,
  output logic        split_out,
  output logic        veggie_gone_out,
  output logic [7:0]  score_out,
  output logic [1:0]  lives_out,
  output logic        game_over_out
);

  import veggie_pkg::*;

  localparam int unsigned BOTTOM_Y = SCREEN_H - VEG_H - BOTTOM_MARGIN;

  veggie_state_t state;

  logic [TIMER_W-1:0] air_count;
  logic [TIMER_W-1:0] wait_count;
  logic               air_done;
  logic               wait_done;
  logic               air_load_c;
  logic               air_tick_c;
  logic               wait_load_c;
  logic               wait_tick_c;
  logic               air_last_c;
  logic               wait_last_c;
  logic               at_bottom_c;
  logic               unused_random_c;

  // Spawn row is a fixed line just above the bottom bound.
  assign spawn_y_out = 10'(BOTTOM_Y - 1);

  // Only the low 12 LFSR bits shape position and velocity.
  assign unused_random_c = ^random_in[15:12];

  // Timer controls: each timer is held loaded until its state is active.
  always_comb begin
    air_load_c  = (state != ST_FLY);
    air_tick_c  = (state == ST_FLY) && frame_done_in;
    wait_load_c = (state != ST_WAIT);
    wait_tick_c = (state == ST_WAIT) && frame_done_in;
    // This strobe completes (or has completed) the minimum airtime.
    air_last_c  = air_done || (air_count == TIMER_W'(1));
    // This strobe is the last respawn frame.
    wait_last_c = wait_done || (wait_count == TIMER_W'(1));
    at_bottom_c = (veggie_y_in >= 10'(BOTTOM_Y));
  end

  frame_timer #(.W(TIMER_W)) u_air_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (air_load_c),
    .load_val (TIMER_W'(MIN_AIR_FRAMES)),
    .tick     (air_tick_c),
    .count    (air_count),
    .done     (air_done)
  );

  frame_timer #(.W(TIMER_W)) u_wait_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (wait_load_c),
    .load_val (TIMER_W'(RESPAWN_FRAMES)),
    .tick     (wait_tick_c),
    .count    (wait_count),
    .done     (wait_done)
  );

  // Round state machine with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= ST_IDLE;
      load_out        <= 1'b0;
      split_out       <= 1'b0;
      veggie_gone_out <= 1'b1;
      spawn_x_out     <= 11'(512);
      x_vel_out       <= 3'd0;
      score_out       <= 8'd0;
      lives_out       <= 2'd0;
      game_over_out   <= 1'b0;
    end else begin
      load_out  <= 1'b0;
      split_out <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_in) begin
            score_out     <= 8'd0;
            lives_out     <= 2'(MAX_LIVES);
            game_over_out <= 1'b0;
            state         <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          spawn_x_out     <= 11'(SPAWN_X_BASE) + 11'(random_in[8:0]);
          x_vel_out       <= random_in[11:9];
          load_out        <= 1'b1;
          veggie_gone_out <= 1'b0;
          state           <= ST_FLY;
        end
        ST_FLY: begin
          if (frame_done_in) begin
            if (hit_in) begin
              // A hit wins over a bottom crossing in the same frame.
              split_out <= 1'b1;
              if (score_out != 8'hFF) score_out <= score_out + 8'd1;
              state <= ST_SLICED;
            end else if (air_last_c && at_bottom_c) begin
              lives_out       <= lives_out - 2'd1;
              veggie_gone_out <= 1'b1;
              if (lives_out == 2'd1) begin
                game_over_out <= 1'b1;
                state         <= ST_OVER;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
        end
        ST_SLICED: begin
          if (frame_done_in && at_bottom_c) begin
            veggie_gone_out <= 1'b1;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (frame_done_in && wait_last_c) state <= ST_SPAWN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_veggie_round_controller.sv
// Bench for veggie_round_controller: directed table, corner sequences, random run vs model.
module tb_veggie_round_controller;

  localparam int MAX_LIVES = 3;
  localparam int MIN_AIR   = 16;
  localparam int RESPAWN   = 30;
  localparam int BOTTOM    = 768 - 64 - 12;

  localparam int PH_IDLE   = 0;
  localparam int PH_SPAWN  = 1;
  localparam int PH_FLY    = 2;
  localparam int PH_SLICED = 3;
  localparam int PH_WAIT   = 4;
  localparam int PH_OVER   = 5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        frame_done_in = 1'b0;
  logic        start_in = 1'b0;
  logic [15:0] random_in = 16'h0;
  logic        hit_in = 1'b0;
  logic [9:0]  veggie_y_in = 10'd0;
  logic        load_out;
  logic [10:0] spawn_x_out;
  logic [9:0]  spawn_y_out;
  logic [2:0]  x_vel_out;
  logic        split_out;
  logic        veggie_gone_out;
  logic [7:0]  score_out;
  logic [1:0]  lives_out;
  logic        game_over_out;

  int total = 0;
  int bad   = 0;

  // Reference model of the round, tracked at frame/event level.
  int          m_phase  = PH_IDLE;
  int          m_air    = 0;
  int          m_waited = 0;
  logic        m_load   = 1'b0;
  logic [10:0] m_x      = 11'd512;
  logic [2:0]  m_vel    = 3'd0;
  logic        m_split  = 1'b0;
  logic        m_gone   = 1'b1;
  logic [7:0]  m_score  = 8'd0;
  logic [1:0]  m_lives  = 2'd0;
  logic        m_over   = 1'b0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        fd;
    logic [15:0] rnd;
    logic        hit;
    logic [9:0]  y;
    logic [27:0] exp;
  } vec_t;

  vec_t vec[8];

  veggie_round_controller dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .frame_done_in   (frame_done_in),
    .start_in        (start_in),
    .random_in       (random_in),
    .hit_in          (hit_in),
    .veggie_y_in     (veggie_y_in),
    .load_out        (load_out),
    .spawn_x_out     (spawn_x_out),
    .spawn_y_out     (spawn_y_out),
    .x_vel_out       (x_vel_out),
    .split_out       (split_out),
    .veggie_gone_out (veggie_gone_out),
    .score_out       (score_out),
    .lives_out       (lives_out),
    .game_over_out   (game_over_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [27:0] pack(input logic l, input logic [10:0] x, input logic [2:0] v,
                                       input logic s, input logic g, input logic [7:0] sc,
                                       input logic [1:0] lv, input logic o);
    return {l, x, v, s, g, sc, lv, o};
  endfunction

  function automatic logic [27:0] dut_outs();
    return {load_out, spawn_x_out, x_vel_out, split_out, veggie_gone_out,
            score_out, lives_out, game_over_out};
  endfunction

  // Advance the model by one clock using the inputs the DUT sees at this edge.
  task automatic model_step();
    if (rst_in) begin
      m_phase = PH_IDLE; m_load = 1'b0; m_x = 11'd512; m_vel = 3'd0; m_split = 1'b0;
      m_gone = 1'b1; m_score = 8'd0; m_lives = 2'd0; m_over = 1'b0;
    end else begin
      m_load  = 1'b0;
      m_split = 1'b0;
      case (m_phase)
        PH_IDLE, PH_OVER: if (start_in) begin
          m_score = 8'd0; m_lives = 2'(MAX_LIVES); m_over = 1'b0; m_phase = PH_SPAWN;
        end
        PH_SPAWN: begin
          m_x = 11'(256 + int'(random_in % 512));
          m_vel = 3'((random_in / 512) % 8);
          m_load = 1'b1; m_gone = 1'b0; m_air = 0; m_phase = PH_FLY;
        end
        PH_FLY: if (frame_done_in) begin
          m_air = (m_air < MIN_AIR) ? m_air + 1 : MIN_AIR;
          if (hit_in) begin
            m_split = 1'b1;
            m_score = (m_score == 8'd255) ? 8'd255 : 8'(int'(m_score) + 1);
            m_phase = PH_SLICED;
          end else if (m_air == MIN_AIR && int'(veggie_y_in) >= BOTTOM) begin
            m_lives = 2'(int'(m_lives) - 1);
            m_gone = 1'b1;
            if (m_lives == 2'd0) begin
              m_over = 1'b1; m_phase = PH_OVER;
            end else begin
              m_waited = 0; m_phase = PH_WAIT;
            end
          end
        end
        PH_SLICED: if (frame_done_in && int'(veggie_y_in) >= BOTTOM) begin
          m_gone = 1'b1; m_waited = 0; m_phase = PH_WAIT;
        end
        PH_WAIT: if (frame_done_in) begin
          m_waited++;
          if (m_waited == RESPAWN) m_phase = PH_SPAWN;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [27:0] act;
    logic [27:0] exp;
    act = dut_outs();
    exp = pack(m_load, m_x, m_vel, m_split, m_gone, m_score, m_lives, m_over);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {load,x,vel,split,gone,score,lives,over}=%h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk_in);
    model_step();
    #1;
    check_model(name);
  endtask

  task automatic do_frame(input string name, input logic hit, input logic [9:0] y);
    hit_in = hit; veggie_y_in = y; frame_done_in = 1'b1; random_in = 16'($urandom);
    step(name);
    hit_in = 1'b0; frame_done_in = 1'b0;
    step(name);
  endtask

  initial begin
    vec[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd0,   pack(1'b0, 11'd512, 3'd0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0)};
    vec[1] = '{1'b0, 1'b1, 1'b1, 16'h0A05, 1'b1, 10'd0,   pack(1'b0, 11'd512, 3'd0, 1'b0, 1'b1, 8'd0, 2'd3, 1'b0)};
    vec[2] = '{1'b0, 1'b0, 1'b0, 16'h0A05, 1'b0, 10'd0,   pack(1'b1, 11'd261, 3'b101, 1'b0, 1'b0, 8'd0, 2'd3, 1'b0)};
    vec[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 10'd100, pack(1'b0, 11'd261, 3'b101, 1'b1, 1'b0, 8'd1, 2'd3, 1'b0)};
    vec[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd100, pack(1'b0, 11'd261, 3'b101, 1'b0, 1'b0, 8'd1, 2'd3, 1'b0)};
    vec[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 10'd100, pack(1'b0, 11'd261, 3'b101, 1'b0, 1'b0, 8'd1, 2'd3, 1'b0)};
    vec[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd700, pack(1'b0, 11'd261, 3'b101, 1'b0, 1'b0, 8'd1, 2'd3, 1'b0)};
    vec[7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 10'd700, pack(1'b0, 11'd261, 3'b101, 1'b0, 1'b1, 8'd1, 2'd3, 1'b0)};

    // Directed table: reset, start (with coincident strobe), spawn, slice, bottom-out.
    for (int i = 0; i < 8; i++) begin
      rst_in = vec[i].rst; start_in = vec[i].start; frame_done_in = vec[i].fd;
      random_in = vec[i].rnd; hit_in = vec[i].hit; veggie_y_in = vec[i].y;
      @(posedge clk_in);
      model_step();
      #1;
      total++;
      if (dut_outs() !== vec[i].exp) begin
        bad++;
        $display("FAIL table[%0d]: got %h expected %h", i, dut_outs(), vec[i].exp);
      end
    end
    start_in = 1'b0; frame_done_in = 1'b0; hit_in = 1'b0;
    check_val("spawn_y", int'(spawn_y_out), BOTTOM - 1);

    // Respawn after exactly RESPAWN strobes.
    for (int i = 0; i < RESPAWN - 1; i++) do_frame("wait", 1'b0, 10'd100);
    check_val("wait_no_early_load", int'(load_out), 0);
    do_frame("wait", 1'b0, 10'd100);
    check_val("respawn_load", int'(load_out), 1);
    check_val("respawn_gone", int'(veggie_gone_out), 0);

    // Bottom ignored during the first frames, then a miss costs a life.
    for (int i = 0; i < MIN_AIR - 1; i++) do_frame("early", 1'b0, 10'd700);
    check_val("early_bottom_lives", int'(lives_out), 3);
    do_frame("miss", 1'b0, 10'd700);
    check_val("miss_lives", int'(lives_out), 2);
    check_val("miss_gone", int'(veggie_gone_out), 1);
    check_val("miss_score", int'(score_out), 1);
    for (int i = 0; i < RESPAWN; i++) do_frame("wait2", 1'b0, 10'd100);

    // Hit and bottom in the same frame: hit wins.
    for (int i = 0; i < MIN_AIR - 1; i++) do_frame("fly", 1'b0, 10'd100);
    do_frame("hit_bottom", 1'b1, 10'd700);
    check_val("hit_bottom_score", int'(score_out), 2);
    check_val("hit_bottom_lives", int'(lives_out), 2);
    check_val("hit_bottom_gone", int'(veggie_gone_out), 0);
    do_frame("sliced_fall", 1'b1, 10'd692);
    check_val("sliced_gone", int'(veggie_gone_out), 1);
    check_val("sliced_score", int'(score_out), 2);
    for (int i = 0; i < RESPAWN; i++) do_frame("wait3", 1'b0, 10'd100);

    // Lose remaining lives to reach game over, then restart.
    for (int i = 0; i < MIN_AIR; i++) do_frame("miss2", 1'b0, 10'd691 + 10'd1);
    check_val("miss2_lives", int'(lives_out), 1);
    for (int i = 0; i < RESPAWN; i++) do_frame("wait4", 1'b0, 10'd100);
    for (int i = 0; i < MIN_AIR; i++) do_frame("miss3", 1'b0, 10'd767);
    check_val("over_flag", int'(game_over_out), 1);
    check_val("over_lives", int'(lives_out), 0);
    for (int i = 0; i < 3; i++) do_frame("over_idle", 1'b1, 10'd100);
    check_val("over_held", int'(game_over_out), 1);
    start_in = 1'b1;
    step("restart");
    start_in = 1'b0;
    step("restart_spawn");
    check_val("restart_load", int'(load_out), 1);
    check_val("restart_score", int'(score_out), 0);
    check_val("restart_lives", int'(lives_out), 3);
    check_val("restart_over", int'(game_over_out), 0);

    // Reset during flight.
    for (int i = 0; i < 5; i++) do_frame("fly_pre_rst", 1'b0, 10'd100);
    rst_in = 1'b1;
    step("mid_reset");
    rst_in = 1'b0;
    check_val("mid_reset_outs", int'(dut_outs()),
              int'(pack(1'b0, 11'd512, 3'd0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0)));

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      rst_in        = ($urandom_range(0, 599) == 0);
      start_in      = ($urandom_range(0, 29) == 0);
      frame_done_in = ($urandom_range(0, 2) == 0);
      hit_in        = ($urandom_range(0, 11) == 0);
      random_in     = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       veggie_y_in = 10'd691;
        1:       veggie_y_in = 10'd692;
        2, 3:    veggie_y_in = 10'($urandom_range(693, 1023));
        default: veggie_y_in = 10'($urandom_range(0, 690));
      endcase
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
